// File: rtl/register_type_sequencer.sv
// Sequences one R-type instruction at a time: accept, read both sources,
// execute on the shared ALU, then commit to rd or raise a trap pulse.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | ready for a new instruction; reads track the incoming rs1/rs2
// READ      | register file data valid; captured into operand registers
// EXECUTE   | operands and subfunctions presented to the ALU
// WRITEBACK | registered ALU result committed to rd (no write when rd == 0)
// TRAP      | ALU reported an illegal encoding; pulse trap, no write
module register_type_sequencer #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH             = 32,
  parameter int COUNTER_WIDTH          = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              instruction_valid,
  output logic                              instruction_ready,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] instruction_rs1,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] instruction_rs2,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] instruction_rd,
  input  logic [2:0]                        instruction_subfunction_3,
  input  logic [6:0]                        instruction_subfunction_7,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] register_read_address1,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] register_read_address2,
  input  logic [DATA_WIDTH-1:0]             register_read_value1,
  input  logic [DATA_WIDTH-1:0]             register_read_value2,
  output logic [2:0]                        alu_subfunction_3,
  output logic [6:0]                        alu_subfunction_7,
  output logic [DATA_WIDTH-1:0]             alu_input_register1_value,
  output logic [DATA_WIDTH-1:0]             alu_input_register2_value,
  input  logic                              alu_error,
  input  logic [DATA_WIDTH-1:0]             alu_result,
  output logic                              register_write_enable,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] register_write_address,
  output logic [DATA_WIDTH-1:0]             register_write_value,
  output logic                              busy,
  output logic                              done,
  output logic                              illegal_instruction,
  output logic [COUNTER_WIDTH-1:0]          retired_count,
  output logic [COUNTER_WIDTH-1:0]          illegal_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_TRAP      = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [REGISTER_ADDRESS_WIDTH-1:0] rs1_q, rs1_d;
  logic [REGISTER_ADDRESS_WIDTH-1:0] rs2_q, rs2_d;
  logic [REGISTER_ADDRESS_WIDTH-1:0] rd_q, rd_d;
  logic [2:0]                        f3_q, f3_d;
  logic [6:0]                        f7_q, f7_d;
  logic [DATA_WIDTH-1:0]             op1_q, op1_d;
  logic [DATA_WIDTH-1:0]             op2_q, op2_d;
  logic [COUNTER_WIDTH-1:0]          retired_q, retired_d;
  logic [COUNTER_WIDTH-1:0]          illegal_q, illegal_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      retired_q <= '0;
      illegal_q <= '0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      f7_q      <= f7_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    f3_d      = f3_q;
    f7_d      = f7_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (instruction_valid) begin
          rs1_d   = instruction_rs1;
          rs2_d   = instruction_rs2;
          rd_d    = instruction_rd;
          f3_d    = instruction_subfunction_3;
          f7_d    = instruction_subfunction_7;
          state_d = S_READ;
        end
      end
      S_READ: begin
        op1_d   = register_read_value1;
        op2_d   = register_read_value2;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = alu_error ? S_TRAP : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        // Retires to x0 still count even though nothing is written.
        if (retired_q != '1) retired_d = retired_q + COUNTER_WIDTH'(1);
        state_d = S_IDLE;
      end
      S_TRAP: begin
        if (illegal_q != '1) illegal_d = illegal_q + COUNTER_WIDTH'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // In IDLE the read ports follow the decoder so the read launches on the accept edge.
  assign register_read_address1 = (state_q == S_IDLE) ? instruction_rs1 : rs1_q;
  assign register_read_address2 = (state_q == S_IDLE) ? instruction_rs2 : rs2_q;

  assign alu_subfunction_3         = f3_q;
  assign alu_subfunction_7         = f7_q;
  assign alu_input_register1_value = op1_q;
  assign alu_input_register2_value = op2_q;

  assign instruction_ready      = (state_q == S_IDLE);
  assign busy                   = (state_q != S_IDLE);
  assign done                   = (state_q == S_WRITEBACK);
  assign illegal_instruction    = (state_q == S_TRAP);
  assign register_write_enable  = (state_q == S_WRITEBACK) && (rd_q != '0);
  assign register_write_address = rd_q;
  assign register_write_value   = alu_result;

  assign retired_count = retired_q;
  assign illegal_count = illegal_q;

endmodule

// File: tb/tb_register_type_sequencer.sv
// Directed bench: register file and ALU models around the sequencer, a vector
// table of single instructions, plus back-to-back, mid-reset and saturation sequences.
module tb_register_type_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [4:0]  instruction_rs1, instruction_rs2, instruction_rd;
  logic [2:0]  instruction_subfunction_3;
  logic [6:0]  instruction_subfunction_7;
  logic [4:0]  register_read_address1, register_read_address2;
  logic [31:0] register_read_value1, register_read_value2;
  logic [2:0]  alu_subfunction_3;
  logic [6:0]  alu_subfunction_7;
  logic [31:0] alu_input_register1_value, alu_input_register2_value;
  logic        alu_error;
  logic [31:0] alu_result;
  logic        register_write_enable;
  logic [4:0]  register_write_address;
  logic [31:0] register_write_value;
  logic        busy, done, illegal_instruction;
  logic [15:0] retired_count, illegal_count;

  // Second instance with 3-bit counters so saturation is reachable quickly.
  logic        s_ready, s_we, s_busy, s_done, s_ill;
  logic [4:0]  s_ra1, s_ra2, s_wa;
  logic [2:0]  s_f3;
  logic [6:0]  s_f7;
  logic [31:0] s_op1, s_op2, s_wv;
  logic [2:0]  s_retired, s_illegal;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ret = 0;
  int exp_ill = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  register_type_sequencer #(.REGISTER_ADDRESS_WIDTH(5), .DATA_WIDTH(32), .COUNTER_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
    .instruction_rs1(instruction_rs1), .instruction_rs2(instruction_rs2), .instruction_rd(instruction_rd),
    .instruction_subfunction_3(instruction_subfunction_3), .instruction_subfunction_7(instruction_subfunction_7),
    .register_read_address1(register_read_address1), .register_read_address2(register_read_address2),
    .register_read_value1(register_read_value1), .register_read_value2(register_read_value2),
    .alu_subfunction_3(alu_subfunction_3), .alu_subfunction_7(alu_subfunction_7),
    .alu_input_register1_value(alu_input_register1_value), .alu_input_register2_value(alu_input_register2_value),
    .alu_error(alu_error), .alu_result(alu_result),
    .register_write_enable(register_write_enable), .register_write_address(register_write_address),
    .register_write_value(register_write_value),
    .busy(busy), .done(done), .illegal_instruction(illegal_instruction),
    .retired_count(retired_count), .illegal_count(illegal_count)
  );

  register_type_sequencer #(.REGISTER_ADDRESS_WIDTH(5), .DATA_WIDTH(32), .COUNTER_WIDTH(3)) dut_small (
    .clk(clk), .reset_n(reset_n),
    .instruction_valid(instruction_valid), .instruction_ready(s_ready),
    .instruction_rs1(instruction_rs1), .instruction_rs2(instruction_rs2), .instruction_rd(instruction_rd),
    .instruction_subfunction_3(instruction_subfunction_3), .instruction_subfunction_7(instruction_subfunction_7),
    .register_read_address1(s_ra1), .register_read_address2(s_ra2),
    .register_read_value1(register_read_value1), .register_read_value2(register_read_value2),
    .alu_subfunction_3(s_f3), .alu_subfunction_7(s_f7),
    .alu_input_register1_value(s_op1), .alu_input_register2_value(s_op2),
    .alu_error(alu_error), .alu_result(alu_result),
    .register_write_enable(s_we), .register_write_address(s_wa), .register_write_value(s_wv),
    .busy(s_busy), .done(s_done), .illegal_instruction(s_ill),
    .retired_count(s_retired), .illegal_count(s_illegal)
  );

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0: alu_model = f7[5] ? a - b : a + b;
      3'd1: alu_model = a << b[4:0];
      3'd2: alu_model = {31'd0, $signed(a) < $signed(b)};
      3'd3: alu_model = {31'd0, a < b};
      3'd4: alu_model = a ^ b;
      3'd5: alu_model = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: alu_model = a | b;
      default: alu_model = a & b;
    endcase
  endfunction

  assign alu_error = !((alu_subfunction_7 == 7'h00) ||
                       (alu_subfunction_7 == 7'h20 && (alu_subfunction_3 == 3'd0 || alu_subfunction_3 == 3'd5)));

  always @(posedge clk) begin
    register_read_value1 <= rf[register_read_address1];
    register_read_value2 <= rf[register_read_address2];
    alu_result <= alu_model(alu_input_register1_value, alu_input_register2_value,
                            alu_subfunction_3, alu_subfunction_7);
    if (register_write_enable && register_write_address != 5'd0)
      rf[register_write_address] <= register_write_value;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!instruction_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_wait", {31'd0, instruction_ready}, 32'd1);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the return-to-IDLE cycle 4.
  task automatic run_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic e_ill, input logic e_we, input logic [31:0] e_val);
    wait_ready();
    instruction_valid = 1'b1;
    instruction_rs1 = rs1; instruction_rs2 = rs2; instruction_rd = rd;
    instruction_subfunction_3 = f3; instruction_subfunction_7 = f7;
    @(posedge clk); #1;
    instruction_valid = 1'b0;
    instruction_rs1 = 5'd31; instruction_rs2 = 5'd31; instruction_rd = 5'd31;
    chk("c1_busy", {31'd0, busy}, 32'd1);
    chk("c1_ready", {31'd0, instruction_ready}, 32'd0);
    @(posedge clk); #1;
    chk("c2_f3", {29'd0, alu_subfunction_3}, {29'd0, f3});
    chk("c2_f7", {25'd0, alu_subfunction_7}, {25'd0, f7});
    chk("c2_we", {31'd0, register_write_enable}, 32'd0);
    @(posedge clk); #1;
    chk("c3_we", {31'd0, register_write_enable}, {31'd0, e_we});
    chk("c3_done", {31'd0, done}, {31'd0, !e_ill});
    chk("c3_illegal", {31'd0, illegal_instruction}, {31'd0, e_ill});
    if (!e_ill) chk("c3_addr", {27'd0, register_write_address}, {27'd0, rd});
    if (e_we) chk("c3_value", register_write_value, e_val);
    if (e_ill) exp_ill++; else exp_ret++;
    @(posedge clk); #1;
    chk("c4_busy", {31'd0, busy}, 32'd0);
    chk("c4_done", {31'd0, done | illegal_instruction}, 32'd0);
    chk("retired_count", {16'd0, retired_count}, exp_ret);
    chk("illegal_count", {16'd0, illegal_count}, exp_ill);
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        e_ill, e_we;
    logic [31:0] e_val;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[5] = 32'd100; rf[6] = 32'd30;

    //          rs1   rs2   rd     f3    f7     ill   we    value
    vecs[0] = '{5'd1, 5'd2, 5'd3,  3'd0, 7'h00, 1'b0, 1'b1, 32'd12};  // ADD x3
    vecs[1] = '{5'd1, 5'd2, 5'd0,  3'd0, 7'h00, 1'b0, 1'b0, 32'd0};   // ADD to x0
    vecs[2] = '{5'd1, 5'd2, 5'd4,  3'd1, 7'h20, 1'b1, 1'b0, 32'd0};   // illegal
    vecs[3] = '{5'd5, 5'd6, 5'd7,  3'd0, 7'h20, 1'b0, 1'b1, 32'd70};  // SUB
    vecs[4] = '{5'd5, 5'd6, 5'd8,  3'd4, 7'h00, 1'b0, 1'b1, 32'd122}; // XOR
    vecs[5] = '{5'd5, 5'd6, 5'd9,  3'd7, 7'h00, 1'b0, 1'b1, 32'd4};   // AND
    vecs[6] = '{5'd5, 5'd6, 5'd10, 3'd6, 7'h00, 1'b0, 1'b1, 32'd126}; // OR
    vecs[7] = '{5'd1, 5'd2, 5'd5,  3'd0, 7'h01, 1'b1, 1'b0, 32'd0};   // illegal f7, must not clobber x5
    vecs[8] = '{5'd3, 5'd7, 5'd11, 3'd0, 7'h00, 1'b0, 1'b1, 32'd82};  // uses earlier writes

    reset_n = 1'b0;
    instruction_valid = 1'b0;
    instruction_rs1 = '0; instruction_rs2 = '0; instruction_rd = '0;
    instruction_subfunction_3 = '0; instruction_subfunction_7 = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, instruction_ready}, 32'd1);
    chk("rst_we", {31'd0, register_write_enable}, 32'd0);
    chk("rst_retired", {16'd0, retired_count}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_instr(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].f3, vecs[i].f7,
                vecs[i].e_ill, vecs[i].e_we, vecs[i].e_val);
    chk("x5_untouched", rf[5], 32'd100);

    // Back-to-back dependent pair with valid held high.
    instruction_valid = 1'b1;
    instruction_rs1 = 5'd1; instruction_rs2 = 5'd2; instruction_rd = 5'd12;
    instruction_subfunction_3 = 3'd0; instruction_subfunction_7 = 7'h00;
    @(posedge clk); #1;
    instruction_rs1 = 5'd12; instruction_rs2 = 5'd12; instruction_rd = 5'd13;
    chk("b2b_c1_ready", {31'd0, instruction_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_c2_ready", {31'd0, instruction_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_c3_addr", {27'd0, register_write_address}, 32'd12);
    chk("b2b_c3_value", register_write_value, 32'd12);
    @(posedge clk); #1;
    chk("b2b_c4_ready", {31'd0, instruction_ready}, 32'd1);
    @(posedge clk); #1;
    instruction_valid = 1'b0;
    chk("b2b_c5_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_c7_we", {31'd0, register_write_enable}, 32'd1);
    chk("b2b_c7_addr", {27'd0, register_write_address}, 32'd13);
    chk("b2b_c7_value", register_write_value, 32'd24);
    exp_ret += 2;
    @(posedge clk); #1;
    chk("b2b_retired", {16'd0, retired_count}, exp_ret);

    // Reset while in EXECUTE discards the instruction.
    instruction_valid = 1'b1;
    instruction_rs1 = 5'd1; instruction_rs2 = 5'd2; instruction_rd = 5'd14;
    @(posedge clk); #1;
    instruction_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, instruction_ready}, 32'd1);
    chk("mid_rst_we", {31'd0, register_write_enable}, 32'd0);
    chk("mid_rst_done", {31'd0, done | illegal_instruction}, 32'd0);
    chk("mid_rst_retired", {16'd0, retired_count}, 32'd0);
    chk("mid_rst_illegal", {16'd0, illegal_count}, 32'd0);
    exp_ret = 0; exp_ill = 0;
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("x14_not_written", rf[14], 32'd0);
    run_instr(5'd1, 5'd2, 5'd15, 3'd0, 7'h00, 1'b0, 1'b1, 32'd12);

    // Saturation on the narrow-counter instance.
    for (int i = 0; i < 8; i++) run_instr(5'd5, 5'd6, 5'd16, 3'd0, 7'h00, 1'b0, 1'b1, 32'd130);
    chk("sat_retired_small", {29'd0, s_retired}, 32'd7);
    for (int i = 0; i < 8; i++) run_instr(5'd1, 5'd2, 5'd17, 3'd2, 7'h20, 1'b1, 1'b0, 32'd0);
    chk("sat_illegal_small", {29'd0, s_illegal}, 32'd7);
    chk("x17_not_written", rf[17], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
